morse_symbol_decoder: RTL and testbench
=======================================

Name: morse_symbol_decoder

Overview:
Upstream stage of the character display path. Samples the Morse key, times marks and spaces against a tick timebase, and assembles dot/dash elements. Closes each character on a letter gap and emits a one-cycle strobe with the character code consumed by the seven-segment display stage.
- Code map: 0x00–0x09 = digits 0–9, 0x0A–0x23 = letters A–Z, 0x3F = invalid.

Parameters:
- DOT_MAX_TICKS, 3: a mark of 1..DOT_MAX_TICKS ticks is a dot; a longer mark is a dash.
- GAP_TICKS, 7: a continuous space of GAP_TICKS ticks closes the current character.
- CNT_W, 8: duration counter width; the counter saturates at 2^CNT_W-1.
- DEBOUNCE_TICKS, 2: stable-tick count used only when MORSE_DEBOUNCE_EN is defined.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- tick, in, 1: single-cycle timebase enable; all durations are counted in ticks.
- key_in, in, 1: raw key input, asynchronous to clk; 1 = pressed.
- char_valid, out, 1: one-cycle strobe; char_code and char_err are valid in this cycle.
- char_code, out, 6: decoded code, held stable until the next strobe.
- char_err, out, 1: high with char_valid when the element pattern is not a valid character.
- elem_count, out, 3: number of elements collected in the current character (0..5).

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. On reset:
  - char_valid = 0, char_code = 0x3F, char_err = 0, elem_count = 0.
  - State = IDLE; counters, pattern register and synchronizer flops cleared.
- key_in passes through a 2-flop synchronizer to give key_s. All decisions use key_s.
- FSM states:
  - IDLE: no character in progress. If key_s = 1, go to MARK and clear the counter.
  - MARK: the counter increments on each tick, saturating. On key_s falling edge:
    - Classify the element: counter ≤ DOT_MAX_TICKS is a dot (0); otherwise a dash (1). A zero-tick mark counts as a dot.
    - Shift the element into pattern[4:0], first element ending up in the MSB of a length-aligned field.
    - Increment elem_count (saturates at 5), set the overflow flag if 5 elements were already present, clear the counter, go to SPACE.
  - SPACE: the counter increments on each tick.
    - If key_s = 1 before the gap expires: go to MARK, clear the counter.
    - If the counter reaches GAP_TICKS on a tick: go to EMIT.
  - EMIT: lasts exactly one cycle.
    - char_valid = 1; char_code = lookup(elem_count, pattern), or 0x3F with char_err = 1 if the lookup misses or overflow is set.
    - Clear pattern, elem_count and overflow.
    - Next state is MARK if key_s = 1 (press coincident with gap expiry is not lost), otherwise IDLE.
- Lookup uses standard ITU Morse for A–Z and 0–9 only. All other length/pattern pairs are invalid.
- Latency: char_valid is asserted the cycle after the tick on which the gap count reaches GAP_TICKS.
- Long mark: the counter saturates and the element is still a dash; there is no timeout.
- The block has no backpressure; the consumer must accept the strobe.

Optional Feature:
- Macro: MORSE_DEBOUNCE_EN.
- Defined: key_s changes only after the synchronized input has differed from key_s for DEBOUNCE_TICKS consecutive ticks. This adds DEBOUNCE_TICKS ticks of latency to both edges.
- Undefined: key_s is the raw 2-flop synchronizer output, and the debounce counter logic is absent.

Decomposition:
- Package morse_pkg holds:
  - The state enum {IDLE, MARK, SPACE, EMIT}.
  - CODE_INVALID = 6'h3F, MAX_ELEMS = 5.
  - The lookup function morse_lookup(len[2:0], pat[4:0]) returning the 6-bit code.
- One sub-module: morse_key_conditioner, containing the synchronizer and the optional debouncer; it outputs key_s.

Test Plan:
All scenarios use the defaults: DOT_MAX_TICKS = 3, GAP_TICKS = 7, tick every 4 clocks.
- Mark 2, space 2, mark 5, space 8 → one char_valid strobe, char_code = 0x0A ("A"), char_err = 0, elem_count returns to 0.
- Single mark of 3 ticks then gap → 0x0E ("E"). Single mark of 4 ticks then gap → 0x1D ("T"), confirming the dot/dash threshold.
- Five 6-tick marks separated by 2-tick spaces, then gap → 0x00 ("0"). Six 1-tick dots, then gap → char_code = 0x3F, char_err = 1.
- Mark held 400 ticks then gap → counter saturates at 255, result 0x1D ("T"), no wrap to dot.
- Key pressed on the cycle of gap expiry → "E" strobe emitted, and the new mark is counted from the next tick, producing a second character.
- rst_n pulsed low mid-MARK after two elements → outputs return to reset values immediately; the next full character decodes correctly with no leftover elements.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared types, constants and the Morse lookup table for the Morse decoder.
// Codes: 0x00-0x09 digits, 0x0A-0x23 letters A-Z, 0x3F invalid.
package morse_pkg;

  typedef enum logic [1:0] {IDLE, MARK, SPACE, EMIT} state_t;

  localparam logic [5:0] CODE_INVALID = 6'h3F;
  localparam logic [2:0] MAX_ELEMS    = 3'd5;

  // pat holds the elements right-aligned: first element in bit len-1, dash = 1.
  function automatic logic [5:0] morse_lookup(input logic [2:0] len, input logic [4:0] pat);
    logic [5:0] code;
    code = CODE_INVALID;
    case (len)
      3'd1: begin
        case (pat[0])
          1'b0:    code = 6'h0E; // E
          default: code = 6'h1D; // T
        endcase
      end
      3'd2: begin
        case (pat[1:0])
          2'b00:   code = 6'h12; // I
          2'b01:   code = 6'h0A; // A
          2'b10:   code = 6'h17; // N
          default: code = 6'h16; // M
        endcase
      end
      3'd3: begin
        case (pat[2:0])
          3'b000:  code = 6'h1C; // S
          3'b001:  code = 6'h1E; // U
          3'b010:  code = 6'h1B; // R
          3'b011:  code = 6'h20; // W
          3'b100:  code = 6'h0D; // D
          3'b101:  code = 6'h14; // K
          3'b110:  code = 6'h10; // G
          default: code = 6'h18; // O
        endcase
      end
      3'd4: begin
        case (pat[3:0])
          4'b0000: code = 6'h11; // H
          4'b0001: code = 6'h1F; // V
          4'b0010: code = 6'h0F; // F
          4'b0100: code = 6'h15; // L
          4'b0110: code = 6'h19; // P
          4'b0111: code = 6'h13; // J
          4'b1000: code = 6'h0B; // B
          4'b1001: code = 6'h21; // X
          4'b1010: code = 6'h0C; // C
          4'b1011: code = 6'h22; // Y
          4'b1100: code = 6'h23; // Z
          4'b1101: code = 6'h1A; // Q
          default: code = CODE_INVALID;
        endcase
      end
      3'd5: begin
        case (pat)
          5'b11111: code = 6'h00;
          5'b01111: code = 6'h01;
          5'b00111: code = 6'h02;
          5'b00011: code = 6'h03;
          5'b00001: code = 6'h04;
          5'b00000: code = 6'h05;
          5'b10000: code = 6'h06;
          5'b11000: code = 6'h07;
          5'b11100: code = 6'h08;
          5'b11110: code = 6'h09;
          default:  code = CODE_INVALID;
        endcase
      end
      default: code = CODE_INVALID;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/morse_key_conditioner.sv
// Brings the asynchronous key into the clk domain (2-flop synchronizer) and,
// when MORSE_DEBOUNCE_EN is defined, debounces it over DEBOUNCE_TICKS ticks.
module morse_key_conditioner
`ifdef MORSE_DEBOUNCE_EN
#(
  parameter int DEBOUNCE_TICKS = 2
)
`endif
(
  input  logic clk,
  input  logic rst_n,
`ifdef MORSE_DEBOUNCE_EN
  input  logic tick,
`endif
  input  logic key_in,
  output logic key_s
);

  logic [1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], key_in};
    end
  end

`ifdef MORSE_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_TICKS + 1);

  logic [DB_W-1:0] db_cnt_reg;
  logic            key_reg;

  // Any tick on which the input agrees with the held level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_reg <= '0;
      key_reg    <= 1'b0;
    end else if (sync_reg[1] == key_reg) begin
      db_cnt_reg <= '0;
    end else if (tick) begin
      if (db_cnt_reg == DB_W'(DEBOUNCE_TICKS - 1)) begin
        key_reg    <= sync_reg[1];
        db_cnt_reg <= '0;
      end else begin
        db_cnt_reg <= db_cnt_reg + DB_W'(1);
      end
    end
  end

  assign key_s = key_reg;
`else
  assign key_s = sync_reg[1];
`endif

endmodule

// File: rtl/morse_symbol_decoder.sv
// Times key marks/spaces in ticks, assembles dot/dash elements and emits one
// character strobe per letter gap. Optional debounce: MORSE_DEBOUNCE_EN.
module morse_symbol_decoder
  import morse_pkg::*;
#(
`ifdef MORSE_DEBOUNCE_EN
  parameter int DEBOUNCE_TICKS = 2,
`endif
  parameter int DOT_MAX_TICKS = 3,
  parameter int GAP_TICKS     = 7,
  parameter int CNT_W         = 8
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       key_in,
  output logic       char_valid,
  output logic [5:0] char_code,
  output logic       char_err,
  output logic [2:0] elem_count
);

  logic key_s;

  morse_key_conditioner
`ifdef MORSE_DEBOUNCE_EN
    #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS))
`endif
  u_key_conditioner (
    .clk    (clk),
    .rst_n  (rst_n),
`ifdef MORSE_DEBOUNCE_EN
    .tick   (tick),
`endif
    .key_in (key_in),
    .key_s  (key_s)
  );

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_sat;
  logic [4:0]       pattern_reg, pattern_next;
  logic [2:0]       elem_count_reg, elem_count_next;
  logic             overflow_reg, overflow_next;
  logic             char_valid_reg, char_valid_next;
  logic [5:0]       char_code_reg, char_code_next;
  logic             char_err_reg, char_err_next;
  logic [5:0]       lookup_code;
  logic             is_dash;

  assign lookup_code = morse_lookup(elem_count_reg, pattern_reg);
  assign cnt_sat     = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + CNT_W'(1);
  assign is_dash     = (cnt_reg > CNT_W'(DOT_MAX_TICKS));

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    pattern_next    = pattern_reg;
    elem_count_next = elem_count_reg;
    overflow_next   = overflow_reg;
    char_valid_next = 1'b0;
    char_code_next  = char_code_reg;
    char_err_next   = char_err_reg;

    case (state_reg)
      IDLE: begin
        if (key_s) begin
          state_next = MARK;
          cnt_next   = '0;
        end
      end
      MARK: begin
        if (!key_s) begin
          pattern_next = {pattern_reg[3:0], is_dash};
          if (elem_count_reg == MAX_ELEMS) begin
            overflow_next = 1'b1;
          end else begin
            elem_count_next = elem_count_reg + 3'd1;
          end
          cnt_next   = '0;
          state_next = SPACE;
        end else if (tick) begin
          cnt_next = cnt_sat;
        end
      end
      SPACE: begin
        // Gap expiry wins over a coincident press; EMIT then picks up the press.
        if (tick && (cnt_reg == CNT_W'(GAP_TICKS - 1))) begin
          state_next      = EMIT;
          cnt_next        = '0;
          char_valid_next = 1'b1;
          if (overflow_reg || (lookup_code == CODE_INVALID)) begin
            char_code_next = CODE_INVALID;
            char_err_next  = 1'b1;
          end else begin
            char_code_next = lookup_code;
            char_err_next  = 1'b0;
          end
        end else if (key_s) begin
          state_next = MARK;
          cnt_next   = '0;
        end else if (tick) begin
          cnt_next = cnt_sat;
        end
      end
      EMIT: begin
        pattern_next    = '0;
        elem_count_next = '0;
        overflow_next   = 1'b0;
        cnt_next        = '0;
        state_next      = key_s ? MARK : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      pattern_reg    <= '0;
      elem_count_reg <= '0;
      overflow_reg   <= 1'b0;
      char_valid_reg <= 1'b0;
      char_code_reg  <= CODE_INVALID;
      char_err_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      pattern_reg    <= pattern_next;
      elem_count_reg <= elem_count_next;
      overflow_reg   <= overflow_next;
      char_valid_reg <= char_valid_next;
      char_code_reg  <= char_code_next;
      char_err_reg   <= char_err_next;
    end
  end

  assign char_valid = char_valid_reg;
  assign char_code  = char_code_reg;
  assign char_err   = char_err_reg;
  assign elem_count = elem_count_reg;

endmodule

// File: tb/tb_morse_symbol_decoder.sv
// Directed bench for morse_symbol_decoder: tick every 4 clocks, key segments
// aligned to whole ticks, strobes logged and compared to hand-decoded codes.
module tb_morse_symbol_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       key_in;
  logic       char_valid;
  logic [5:0] char_code;
  logic       char_err;
  logic [2:0] elem_count;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_idx = 0;

  logic [5:0] log_code[$];
  logic       log_err[$];

  morse_symbol_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .key_in     (key_in),
    .char_valid (char_valid),
    .char_code  (char_code),
    .char_err   (char_err),
    .elem_count (elem_count)
  );

  always #5 clk = ~clk;

  // All time passes here so the tick phase stays locked to edge_idx.
  task automatic hold(input logic k, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (char_valid === 1'b1) begin
        log_code.push_back(char_code);
        log_err.push_back(char_err);
      end
      edge_idx++;
      tick   = (edge_idx % 4 == 0);
      key_in = k;
    end
  endtask

  task automatic align();
    while (edge_idx % 4 != 0) hold(1'b0, 1);
  endtask

  task automatic mark_space(input int m, input int s);
    hold(1'b1, 4 * m);
    hold(1'b0, 4 * s);
  endtask

  function automatic logic [5:0] code_at(input int idx);
    if (idx < log_code.size()) return log_code[idx];
    return 6'bxxxxxx;
  endfunction

  function automatic logic err_at(input int idx);
    if (idx < log_err.size()) return log_err[idx];
    return 1'bx;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; tick = 1'b0; key_in = 1'b0;
    hold(1'b0, 3);
    n_cmp++; if (char_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", char_valid); end
    n_cmp++; if (char_code !== 6'h3F) begin n_bad++; $display("FAIL reset_code: got %h want 3f", char_code); end
    n_cmp++; if (char_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", char_err); end
    n_cmp++; if (elem_count !== 3'd0) begin n_bad++; $display("FAIL reset_elem: got %0d want 0", elem_count); end
    rst_n = 1'b1;
    hold(1'b0, 8);
    n_cmp++; if (char_code !== 6'h3F || char_valid !== 1'b0) begin n_bad++; $display("FAIL idle_after_reset: got valid=%b code=%h want valid=0 code=3f", char_valid, char_code); end
    $display("test_reset done");
  endtask

  task automatic test_letter_a();
    int base;
    align(); base = log_code.size();
    mark_space(2, 2);
    mark_space(5, 8);
    n_cmp++; if (log_code.size() !== base + 1) begin n_bad++; $display("FAIL a_count: got %0d want %0d", log_code.size(), base + 1); end
    n_cmp++; if (code_at(base) !== 6'h0A) begin n_bad++; $display("FAIL a_code: got %h want 0a", code_at(base)); end
    n_cmp++; if (err_at(base) !== 1'b0) begin n_bad++; $display("FAIL a_err: got %b want 0", err_at(base)); end
    n_cmp++; if (elem_count !== 3'd0) begin n_bad++; $display("FAIL a_elem: got %0d want 0", elem_count); end
    $display("test_letter_a: code=%h err=%b", code_at(base), err_at(base));
  endtask

  task automatic test_threshold();
    int base;
    align(); base = log_code.size();
    hold(1'b1, 12);                 // 3-tick mark: dot
    hold(1'b0, 28);                 // observing state after the 6th gap tick
    n_cmp++; if (char_valid !== 1'b0) begin n_bad++; $display("FAIL e_early: got %b want 0", char_valid); end
    hold(1'b0, 1);                  // cycle after the 7th gap tick
    n_cmp++; if (char_valid !== 1'b1) begin n_bad++; $display("FAIL e_latency: got %b want 1", char_valid); end
    n_cmp++; if (char_code !== 6'h0E || char_err !== 1'b0) begin n_bad++; $display("FAIL e_code: got %h err=%b want 0e err=0", char_code, char_err); end
    hold(1'b0, 1);
    n_cmp++; if (char_valid !== 1'b0) begin n_bad++; $display("FAIL e_one_cycle: got %b want 0", char_valid); end
    n_cmp++; if (char_code !== 6'h0E) begin n_bad++; $display("FAIL e_held: got %h want 0e", char_code); end
    hold(1'b0, 8);
    mark_space(4, 8);               // 4-tick mark: dash
    n_cmp++; if (log_code.size() !== base + 2) begin n_bad++; $display("FAIL et_count: got %0d want %0d", log_code.size(), base + 2); end
    n_cmp++; if (code_at(base + 1) !== 6'h1D || err_at(base + 1) !== 1'b0) begin n_bad++; $display("FAIL t_code: got %h err=%b want 1d err=0", code_at(base + 1), err_at(base + 1)); end
    $display("test_threshold: E=%h T=%h", code_at(base), code_at(base + 1));
  endtask

  task automatic test_five_elems();
    int base;
    align(); base = log_code.size();
    for (int i = 0; i < 4; i++) mark_space(6, 2);
    mark_space(6, 8);
    n_cmp++; if (code_at(base) !== 6'h00 || err_at(base) !== 1'b0) begin n_bad++; $display("FAIL zero_code: got %h err=%b want 00 err=0", code_at(base), err_at(base)); end
    for (int i = 0; i < 3; i++) mark_space(1, 2);
    n_cmp++; if (elem_count !== 3'd3) begin n_bad++; $display("FAIL dots3_elem: got %0d want 3", elem_count); end
    for (int i = 0; i < 3; i++) mark_space(1, 2);
    n_cmp++; if (elem_count !== 3'd5) begin n_bad++; $display("FAIL dots6_elem_sat: got %0d want 5", elem_count); end
    hold(1'b0, 32);
    n_cmp++; if (log_code.size() !== base + 2) begin n_bad++; $display("FAIL five_count: got %0d want %0d", log_code.size(), base + 2); end
    n_cmp++; if (code_at(base + 1) !== 6'h3F || err_at(base + 1) !== 1'b1) begin n_bad++; $display("FAIL overflow_code: got %h err=%b want 3f err=1", code_at(base + 1), err_at(base + 1)); end
    n_cmp++; if (elem_count !== 3'd0) begin n_bad++; $display("FAIL overflow_elem_clr: got %0d want 0", elem_count); end
    $display("test_five_elems: zero=%h six_dots=%h err=%b", code_at(base), code_at(base + 1), err_at(base + 1));
  endtask

  task automatic test_long_mark();
    int base;
    align(); base = log_code.size();
    mark_space(400, 8);
    n_cmp++; if (log_code.size() !== base + 1) begin n_bad++; $display("FAIL long_count: got %0d want %0d", log_code.size(), base + 1); end
    n_cmp++; if (code_at(base) !== 6'h1D || err_at(base) !== 1'b0) begin n_bad++; $display("FAIL long_code: got %h err=%b want 1d err=0", code_at(base), err_at(base)); end
    $display("test_long_mark: code=%h", code_at(base));
  endtask

  task automatic test_back_to_back();
    int base;
    align(); base = log_code.size();
    hold(1'b1, 4);                  // dot
    hold(1'b0, 25);                 // synchronized press lands on the 7th gap tick
    hold(1'b1, 8);                  // second mark spans one counted tick: dot
    hold(1'b0, 48);
    n_cmp++; if (log_code.size() !== base + 2) begin n_bad++; $display("FAIL b2b_count: got %0d want %0d", log_code.size(), base + 2); end
    n_cmp++; if (code_at(base) !== 6'h0E) begin n_bad++; $display("FAIL b2b_first: got %h want 0e", code_at(base)); end
    n_cmp++; if (code_at(base + 1) !== 6'h0E || err_at(base + 1) !== 1'b0) begin n_bad++; $display("FAIL b2b_second: got %h err=%b want 0e err=0", code_at(base + 1), err_at(base + 1)); end
    $display("test_back_to_back: first=%h second=%h", code_at(base), code_at(base + 1));
  endtask

  task automatic test_reset_mid_mark();
    int base;
    align();
    mark_space(2, 2);
    mark_space(5, 2);
    hold(1'b1, 8);
    n_cmp++; if (elem_count !== 3'd2) begin n_bad++; $display("FAIL pre_reset_elem: got %0d want 2", elem_count); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (char_valid !== 1'b0 || char_err !== 1'b0) begin n_bad++; $display("FAIL async_reset_flags: got valid=%b err=%b want 0 0", char_valid, char_err); end
    n_cmp++; if (char_code !== 6'h3F) begin n_bad++; $display("FAIL async_reset_code: got %h want 3f", char_code); end
    n_cmp++; if (elem_count !== 3'd0) begin n_bad++; $display("FAIL async_reset_elem: got %0d want 0", elem_count); end
    hold(1'b0, 3);
    rst_n = 1'b1;
    align(); base = log_code.size();
    mark_space(5, 2);
    mark_space(2, 2);
    mark_space(5, 8);
    n_cmp++; if (log_code.size() !== base + 1) begin n_bad++; $display("FAIL k_count: got %0d want %0d", log_code.size(), base + 1); end
    n_cmp++; if (code_at(base) !== 6'h14 || err_at(base) !== 1'b0) begin n_bad++; $display("FAIL k_code: got %h err=%b want 14 err=0", code_at(base), err_at(base)); end
    $display("test_reset_mid_mark: code=%h", code_at(base));
  endtask

  initial begin
    test_reset();
    test_letter_a();
    test_threshold();
    test_five_elems();
    test_long_mark();
    test_back_to_back();
    test_reset_mid_mark();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
